// File: rtl/note_playback.sv
// note_playback: reads 48-bit measure words from the note RAM and replays the
// eight eighth-note slots of each measure at the selected tempo. It drives the
// note code, a per-slot strobe, a metronome click and a square-wave tone.
module note_playback #(
  parameter int unsigned MEASURES     = 20,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned SLOT_120     = 18562500,
  parameter int unsigned SLOT_80      = 27843750,
  parameter int unsigned SLOT_60      = 37125000,
  parameter int unsigned CLICK_LEN    = 200000,
  parameter int unsigned CLK_HZ       = 74250000
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        play_in,
  input  logic [1:0]  BPM,
  output logic [4:0]  mem_addr_out,
  input  logic [47:0] mem_data_in,
  output logic [5:0]  note_out,
  output logic        note_strobe,
  output logic        playing_out,
  output logic        done_out,
  output logic        metronome,
  output logic        audio_out
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WORD_W = 48;
  localparam int unsigned NOTE_W = 6;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CNT_W  = 26;
  localparam int unsigned TONE_W = 18;
  localparam int unsigned LUT_N  = 22;
  localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  // Half-period table entries are stored for a 74.25 MHz clock and rescaled
  // to CLK_HZ with rounding, so slower clocks get a proportionally scaled table.
  function automatic logic [TONE_W-1:0] tone_half(input logic [31:0] base);
    logic [63:0] v;
    v = (64'(base) * 64'(CLK_HZ) + 64'd37125000) / 64'd74250000;
    if (v == 64'd0) v = 64'd1;
    return TONE_W'(v);
  endfunction

  // Codes 6'h20..6'h35 map to C4..A5 in semitone steps.
  localparam logic [TONE_W-1:0] HALF_LUT [LUT_N] = '{
    tone_half(32'd141901), tone_half(32'd133937), tone_half(32'd126420),
    tone_half(32'd119324), tone_half(32'd112627), tone_half(32'd106306),
    tone_half(32'd100339), tone_half(32'd94708),  tone_half(32'd89392),
    tone_half(32'd84375),  tone_half(32'd79639),  tone_half(32'd75170),
    tone_half(32'd70951),  tone_half(32'd66968),  tone_half(32'd63210),
    tone_half(32'd59662),  tone_half(32'd56314),  tone_half(32'd53153),
    tone_half(32'd50170),  tone_half(32'd47354),  tone_half(32'd44696),
    tone_half(32'd42188)
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_play;
  logic                r_play_d;

  logic [LAT_W-1:0]    r_fetch_cnt;
  logic                r_nf_busy;
  logic [LAT_W-1:0]    r_nf_cnt;
  logic [ADDR_W-1:0]   r_measure;
  logic [SLOT_W-1:0]   r_slot;
  logic [CNT_W-1:0]    r_slot_cnt;
  logic [CNT_W-1:0]    r_slot_len;
  logic [WORD_W-1:0]   r_cur_word;
  logic [WORD_W-1:0]   r_next_word;

  logic [ADDR_W-1:0]   r_addr;
  logic [NOTE_W-1:0]   r_note;
  logic                r_strobe;
  logic                r_playing;
  logic                r_done;
  logic                r_metronome;
  logic                r_audio;
  logic [TONE_W-1:0]   r_tone_cnt;

  logic                w_start;
  logic                w_fetch_done;
  logic                w_new_slot;
  logic                w_new_measure;
  logic                w_finish;

  logic [SLOT_W-1:0]   w_slot_nxt;
  logic [CNT_W-1:0]    w_slot_cnt_nxt;
  logic [CNT_W-1:0]    w_slot_len_sel;
  logic [WORD_W-1:0]   w_word_src;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic                w_slot7_start;
  logic                w_pitched;
  logic [4:0]          w_lut_idx;
  logic [TONE_W-1:0]   w_half;

  assign mem_addr_out = r_addr;
  assign note_out     = r_note;
  assign note_strobe  = r_strobe;
  assign playing_out  = r_playing;
  assign done_out     = r_done;
  assign metronome    = r_metronome;
  assign audio_out    = r_audio;

  // Register play_in once, keep one more stage for rise detection.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_play   <= 1'b0;
      r_play_d <= 1'b0;
    end else begin
      r_play   <= play_in;
      r_play_d <= r_play;
    end
  end

  // FSM state register.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state and the sequencing events it raises this cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_fetch_done  = 1'b0;
    w_new_slot    = 1'b0;
    w_new_measure = 1'b0;
    w_finish      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_start = r_play & ~r_play_d;
        if (w_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!r_play) begin
          w_state_nxt = ST_IDLE;
        end else if (r_fetch_cnt == LAT_W'(READ_LATENCY - 1)) begin
          w_fetch_done = 1'b1;
          w_new_slot   = 1'b1;
          w_state_nxt  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!r_play) begin
          w_state_nxt = ST_IDLE;
        end else if (r_slot_cnt == r_slot_len - CNT_W'(1)) begin
          if (r_slot != SLOT_W'(7)) begin
            w_new_slot = 1'b1;
          end else if (r_measure != ADDR_W'(MEASURES - 1)) begin
            w_new_slot    = 1'b1;
            w_new_measure = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next slot index, slot period selection and the note code of the next slot.
  always_comb begin
    w_slot_nxt     = '0;
    w_slot_cnt_nxt = '0;
    w_slot_len_sel = CNT_W'(SLOT_60);
    w_word_src     = r_cur_word;
    w_note_nxt     = '0;
    w_slot7_start  = 1'b0;
    if (r_state == ST_PLAY) w_slot_nxt = r_slot + SLOT_W'(1);
    if (!w_new_slot)        w_slot_cnt_nxt = r_slot_cnt + CNT_W'(1);
    unique case (BPM)
      2'b10:   w_slot_len_sel = CNT_W'(SLOT_120);
      2'b01:   w_slot_len_sel = CNT_W'(SLOT_80);
      default: w_slot_len_sel = CNT_W'(SLOT_60);
    endcase
    if (w_fetch_done)       w_word_src = mem_data_in;
    else if (w_new_measure) w_word_src = r_next_word;
    for (int k = 0; k < 8; k++) begin
      if (w_slot_nxt == SLOT_W'(k)) w_note_nxt = w_word_src[6*k +: 6];
    end
    w_slot7_start = w_new_slot && (r_state == ST_PLAY) && (r_slot == SLOT_W'(6));
  end

  // Measure/slot sequencing, word fetches and the RAM address.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fetch_cnt <= '0;
      r_nf_busy   <= 1'b0;
      r_nf_cnt    <= '0;
      r_measure   <= '0;
      r_slot      <= '0;
      r_slot_cnt  <= '0;
      r_slot_len  <= '0;
      r_cur_word  <= '0;
      r_next_word <= '0;
      r_addr      <= '0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_fetch_cnt <= '0;
      r_nf_busy   <= 1'b0;
      r_nf_cnt    <= '0;
      r_measure   <= '0;
      r_slot      <= '0;
      r_slot_cnt  <= '0;
      r_slot_len  <= '0;
      r_cur_word  <= '0;
      r_next_word <= '0;
      r_addr      <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= '0;
        r_measure   <= '0;
        r_fetch_cnt <= '0;
      end else if (r_state == ST_FETCH && !w_fetch_done) begin
        r_fetch_cnt <= r_fetch_cnt + LAT_W'(1);
      end
      if (w_new_slot) begin
        r_slot_cnt <= '0;
        r_slot_len <= w_slot_len_sel;
        r_slot     <= w_slot_nxt;
      end else if (r_state == ST_PLAY) begin
        r_slot_cnt <= w_slot_cnt_nxt;
      end
      if (w_fetch_done || w_new_measure) r_cur_word <= w_word_src;
      if (w_new_measure) r_measure <= r_measure + ADDR_W'(1);
      // Prefetch the following measure while its predecessor plays slot 7.
      if (w_slot7_start && (r_measure != ADDR_W'(MEASURES - 1))) begin
        r_addr    <= r_measure + ADDR_W'(1);
        r_nf_busy <= 1'b1;
        r_nf_cnt  <= '0;
      end else if (r_nf_busy) begin
        if (r_nf_cnt == LAT_W'(READ_LATENCY - 1)) begin
          r_next_word <= mem_data_in;
          r_nf_busy   <= 1'b0;
        end else begin
          r_nf_cnt <= r_nf_cnt + LAT_W'(1);
        end
      end
    end
  end

  // Note, strobe, status and metronome outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_note      <= '0;
      r_strobe    <= 1'b0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
      r_metronome <= 1'b0;
    end else begin
      r_strobe    <= w_new_slot;
      r_done      <= w_finish;
      r_playing   <= (w_state_nxt != ST_IDLE);
      r_metronome <= (w_state_nxt == ST_PLAY) && (w_slot_cnt_nxt < CNT_W'(CLICK_LEN));
      if (w_state_nxt != ST_PLAY) r_note <= '0;
      else if (w_new_slot)        r_note <= w_note_nxt;
    end
  end

  // Tone lookup for the note currently on note_out.
  always_comb begin
    w_pitched = (r_note >= 6'h20) && (r_note <= 6'h35);
    w_lut_idx = 5'(r_note - 6'h20);
    w_half    = w_pitched ? HALF_LUT[w_lut_idx] : TONE_W'(1);
  end

  // Square-wave generator; a tied note keeps its phase across the strobe.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tone_cnt <= '0;
      r_audio    <= 1'b0;
    end else if (w_state_nxt != ST_PLAY) begin
      r_tone_cnt <= '0;
      r_audio    <= 1'b0;
    end else if (w_new_slot && (w_note_nxt != r_note)) begin
      r_tone_cnt <= '0;
      r_audio    <= 1'b0;
    end else if (!w_pitched) begin
      r_tone_cnt <= '0;
      r_audio    <= 1'b0;
    end else if (r_tone_cnt == w_half - TONE_W'(1)) begin
      r_tone_cnt <= '0;
      r_audio    <= ~r_audio;
    end else begin
      r_tone_cnt <= r_tone_cnt + TONE_W'(1);
    end
  end

endmodule
